// File: rtl/register_bank.sv
// Dual-port byte-maskable register bank that zeroes itself after reset.
// Read data is registered and arrives 1 cycle after the access.
// There is no backpressure. Both ports are always ready, except that accesses are ignored while CLR_BUSY is high.
module register_bank #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int NB = WIDTH / 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             A_EN,
    input  logic             A_WEN,
    input  logic [NB-1:0]    A_BE,
    input  logic [AW-1:0]    A_ADDR,
    input  logic [WIDTH-1:0] A_DIN,
    output logic [WIDTH-1:0] A_DOUT,
    input  logic             B_EN,
    input  logic             B_WEN,
    input  logic [NB-1:0]    B_BE,
    input  logic [AW-1:0]    B_ADDR,
    input  logic [WIDTH-1:0] B_DIN,
    output logic [WIDTH-1:0] B_DOUT,
    output logic             CLR_BUSY
);

    localparam logic [0:0]    ST_CLEAR = 1'b0;
    localparam logic [0:0]    ST_RUN   = 1'b1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [0:0]       state;
    logic [AW-1:0]    clr_idx;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             a_wr;
    logic             b_wr;
    logic [WIDTH-1:0] a_post;
    logic [WIDTH-1:0] b_post;

    assign a_wr     = (state == ST_RUN) && A_EN && A_WEN;
    assign b_wr     = (state == ST_RUN) && B_EN && B_WEN;
    assign CLR_BUSY = (state == ST_CLEAR);

    // Post-write view of each port's address: B bytes first, then A bytes on top so A wins overlapping bytes.
    always_comb begin
        a_post = mem[A_ADDR];
        b_post = mem[B_ADDR];
        for (int i = 0; i < NB; i++) begin
            if (b_wr && (B_ADDR == A_ADDR) && B_BE[i]) a_post[8*i +: 8] = B_DIN[8*i +: 8];
            if (a_wr && A_BE[i])                       a_post[8*i +: 8] = A_DIN[8*i +: 8];
            if (b_wr && B_BE[i])                       b_post[8*i +: 8] = B_DIN[8*i +: 8];
            if (a_wr && (A_ADDR == B_ADDR) && A_BE[i]) b_post[8*i +: 8] = A_DIN[8*i +: 8];
        end
    end

    // Clear sequencer: wipe one register per cycle, then hand over to normal operation.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
        end else if (state == ST_CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == LAST_IDX) state <= ST_RUN;
        end
    end

    // Storage is not reset. It is zeroed by the sequencer, and no write may land on an edge where RESET is high.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (state == ST_CLEAR) begin
                mem[clr_idx] <= '0;
            end else begin
                if (a_wr) mem[A_ADDR] <= a_post;
                if (b_wr) mem[B_ADDR] <= b_post;
            end
        end
    end

    // Registered read data. It is write-first, it bypasses the other port's write, and it is held at zero during clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            A_DOUT <= '0;
            B_DOUT <= '0;
        end else if (state == ST_CLEAR) begin
            A_DOUT <= '0;
            B_DOUT <= '0;
        end else begin
            if (A_EN) A_DOUT <= a_post;
            if (B_EN) B_DOUT <= b_post;
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank, covering the default 16x16 instance and a 32-bit x 8 instance.
// Checks are taken 1 time unit after each rising edge.
// The DUT applies no backpressure, so a stimulus vector is applied every cycle.
module tb_register_bank;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Default instance: WIDTH=16, DEPTH=16
    logic        rst16;
    logic        a16_en, a16_wen, b16_en, b16_wen;
    logic [1:0]  a16_be, b16_be;
    logic [3:0]  a16_addr, b16_addr;
    logic [15:0] a16_din, b16_din, a16_dout, b16_dout;
    logic        busy16;

    register_bank dut16 (
        .CLK(clk), .RESET(rst16),
        .A_EN(a16_en), .A_WEN(a16_wen), .A_BE(a16_be), .A_ADDR(a16_addr),
        .A_DIN(a16_din), .A_DOUT(a16_dout),
        .B_EN(b16_en), .B_WEN(b16_wen), .B_BE(b16_be), .B_ADDR(b16_addr),
        .B_DIN(b16_din), .B_DOUT(b16_dout),
        .CLR_BUSY(busy16)
    );

    // Wide instance: WIDTH=32, DEPTH=8
    logic        rst32;
    logic        a32_en, a32_wen, b32_en, b32_wen;
    logic [3:0]  a32_be, b32_be;
    logic [2:0]  a32_addr, b32_addr;
    logic [31:0] a32_din, b32_din, a32_dout, b32_dout;
    logic        busy32;

    register_bank #(.WIDTH(32), .DEPTH(8)) dut32 (
        .CLK(clk), .RESET(rst32),
        .A_EN(a32_en), .A_WEN(a32_wen), .A_BE(a32_be), .A_ADDR(a32_addr),
        .A_DIN(a32_din), .A_DOUT(a32_dout),
        .B_EN(b32_en), .B_WEN(b32_wen), .B_BE(b32_be), .B_ADDR(b32_addr),
        .B_DIN(b32_din), .B_DOUT(b32_dout),
        .CLR_BUSY(busy32)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle16();
        a16_en = 0; a16_wen = 0; a16_be = 2'b00; a16_addr = 4'd0; a16_din = 16'h0;
        b16_en = 0; b16_wen = 0; b16_be = 2'b00; b16_addr = 4'd0; b16_din = 16'h0;
    endtask

    task automatic idle32();
        a32_en = 0; a32_wen = 0; a32_be = 4'h0; a32_addr = 3'd0; a32_din = 32'h0;
        b32_en = 0; b32_wen = 0; b32_be = 4'h0; b32_addr = 3'd0; b32_din = 32'h0;
    endtask

    task automatic wr_a16(input logic [3:0] addr, input logic [15:0] din, input logic [1:0] be);
        a16_en = 1; a16_wen = 1; a16_addr = addr; a16_din = din; a16_be = be;
    endtask

    task automatic wr_b16(input logic [3:0] addr, input logic [15:0] din, input logic [1:0] be);
        b16_en = 1; b16_wen = 1; b16_addr = addr; b16_din = din; b16_be = be;
    endtask

    task automatic test_reset();
        int n;
        idle16();
        rst16 = 1;
        tick(); tick();
        checks++;
        if (a16_dout !== 16'h0 || b16_dout !== 16'h0 || busy16 !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: a=%h b=%h busy=%b, required 0000 0000 1", a16_dout, b16_dout, busy16);
        end
        rst16 = 0;
        n = 0;
        while (busy16 === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL clear_len: busy for %0d cycles, required 16", n);
        end
    endtask

    task automatic test_read_all_zero();
        for (int i = 0; i < 16; i++) begin
            idle16();
            a16_en = 1; a16_addr = 4'(i);
            b16_en = 1; b16_addr = 4'(15 - i);
            tick();
            checks++;
            if (a16_dout !== 16'h0 || b16_dout !== 16'h0) begin
                errors++;
                $display("FAIL zero_read[%0d]: a=%h b=%h, required 0000 0000", i, a16_dout, b16_dout);
            end
        end
        idle16();
    endtask

    task automatic test_bypass();
        idle16();
        wr_a16(4'd3, 16'hBEEF, 2'b11);
        b16_en = 1; b16_addr = 4'd3;
        tick();
        checks++;
        if (b16_dout !== 16'hBEEF || a16_dout !== 16'hBEEF) begin
            errors++;
            $display("FAIL bypass: a=%h b=%h, required beef beef", a16_dout, b16_dout);
        end
        idle16();
    endtask

    task automatic test_collision();
        idle16();
        wr_a16(4'd5, 16'h1234, 2'b11);
        tick();
        idle16();
        wr_a16(4'd5, 16'hAA00, 2'b10);
        wr_b16(4'd5, 16'h00BB, 2'b11);
        tick();
        checks++;
        if (a16_dout !== 16'hAABB || b16_dout !== 16'hAABB) begin
            errors++;
            $display("FAIL collision: a=%h b=%h, required aabb aabb", a16_dout, b16_dout);
        end
        idle16();
        b16_en = 1; b16_addr = 4'd5;
        tick();
        checks++;
        if (b16_dout !== 16'hAABB) begin
            errors++;
            $display("FAIL collision_stored: b=%h, required aabb", b16_dout);
        end
        idle16();
    endtask

    task automatic test_byte_enable();
        idle16();
        wr_a16(4'd7, 16'h5678, 2'b11);
        tick();
        wr_a16(4'd7, 16'hFFFF, 2'b01);
        tick();
        checks++;
        if (a16_dout !== 16'h56FF) begin
            errors++;
            $display("FAIL be_low: a=%h, required 56ff", a16_dout);
        end
        wr_a16(4'd7, 16'h0000, 2'b00);
        tick();
        checks++;
        if (a16_dout !== 16'h56FF) begin
            errors++;
            $display("FAIL be_none: a=%h, required 56ff", a16_dout);
        end
        // With the enable low, a write strobe must do nothing and DOUT must hold its value
        idle16();
        a16_wen = 1; a16_be = 2'b11; a16_addr = 4'd3; a16_din = 16'h0000;
        tick();
        checks++;
        if (a16_dout !== 16'h56FF) begin
            errors++;
            $display("FAIL en_low_hold: a=%h, required 56ff", a16_dout);
        end
        idle16();
        a16_en = 1; a16_addr = 4'd3;
        tick();
        checks++;
        if (a16_dout !== 16'hBEEF) begin
            errors++;
            $display("FAIL en_low_nowrite: a=%h, required beef", a16_dout);
        end
        idle16();
    endtask

    task automatic test_back_to_back();
        idle16();
        wr_a16(4'd1, 16'h1111, 2'b11);
        wr_b16(4'd2, 16'h2222, 2'b11);
        tick();
        idle16();
        a16_en = 1; a16_addr = 4'd2;
        b16_en = 1; b16_addr = 4'd1;
        tick();
        checks++;
        if (a16_dout !== 16'h2222 || b16_dout !== 16'h1111) begin
            errors++;
            $display("FAIL diff_addr: a=%h b=%h, required 2222 1111", a16_dout, b16_dout);
        end
        idle16();
    endtask

    task automatic test_clear_restart();
        int n;
        // Assert reset between clock edges; the outputs must respond without waiting for an edge
        idle16();
        a16_en = 1; a16_addr = 4'd1;
        tick();
        #2 rst16 = 1;
        #1;
        checks++;
        if (a16_dout !== 16'h0 || busy16 !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: a=%h busy=%b, required 0000 1", a16_dout, busy16);
        end
        tick();
        rst16 = 0;
        for (int c = 1; c <= 10; c++) begin
            idle16();
            if (c == 4) begin
                wr_a16(4'd0, 16'hDEAD, 2'b11);
                wr_b16(4'd1, 16'hCAFE, 2'b11);
            end
            tick();
        end
        checks++;
        if (busy16 !== 1'b1 || a16_dout !== 16'h0 || b16_dout !== 16'h0) begin
            errors++;
            $display("FAIL clear_mid: busy=%b a=%h b=%h, required 1 0000 0000", busy16, a16_dout, b16_dout);
        end
        rst16 = 1;
        tick();
        rst16 = 0;
        n = 0;
        while (busy16 === 1'b1 && n < 100) begin
            idle16();
            if (n == 4) begin
                wr_a16(4'd0, 16'hDEAD, 2'b11);
                wr_b16(4'd1, 16'hCAFE, 2'b11);
            end
            tick();
            n++;
            if (n == 5) begin
                checks++;
                if (a16_dout !== 16'h0 || b16_dout !== 16'h0) begin
                    errors++;
                    $display("FAIL clear_dout: a=%h b=%h, required 0000 0000", a16_dout, b16_dout);
                end
            end
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL restart_len: busy for %0d cycles, required 16", n);
        end
        idle16();
        a16_en = 1; a16_addr = 4'd0;
        b16_en = 1; b16_addr = 4'd1;
        tick();
        checks++;
        if (a16_dout !== 16'h0 || b16_dout !== 16'h0) begin
            errors++;
            $display("FAIL clear_drop: a=%h b=%h, required 0000 0000", a16_dout, b16_dout);
        end
        idle16();
    endtask

    task automatic test_wide();
        int n;
        idle32();
        rst32 = 1;
        tick();
        rst32 = 0;
        n = 0;
        while (busy32 === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL wide_clear_len: busy for %0d cycles, required 8", n);
        end
        a32_en = 1; a32_wen = 1; a32_addr = 3'd6; a32_din = 32'h11223344; a32_be = 4'hF;
        tick();
        a32_din = 32'hAABBCCDD; a32_be = 4'b0101;
        tick();
        checks++;
        if (a32_dout !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL wide_be0101: a=%h, required 11bb33dd", a32_dout);
        end
        a32_din = 32'hEEFF0099; a32_be = 4'b1010;
        tick();
        checks++;
        if (a32_dout !== 32'hEEBB00DD) begin
            errors++;
            $display("FAIL wide_be1010: a=%h, required eebb00dd", a32_dout);
        end
        a32_din = 32'h0000A1A2; a32_be = 4'b0011;
        b32_en = 1; b32_wen = 1; b32_addr = 3'd6; b32_din = 32'h00B1B200; b32_be = 4'b0110;
        tick();
        checks++;
        if (a32_dout !== 32'hEEB1A1A2 || b32_dout !== 32'hEEB1A1A2) begin
            errors++;
            $display("FAIL wide_collision: a=%h b=%h, required eeb1a1a2", a32_dout, b32_dout);
        end
        idle32();
        b32_en = 1; b32_addr = 3'd6;
        tick();
        checks++;
        if (b32_dout !== 32'hEEB1A1A2) begin
            errors++;
            $display("FAIL wide_stored: b=%h, required eeb1a1a2", b32_dout);
        end
        idle32();
    endtask

    initial begin
        rst16 = 1;
        rst32 = 1;
        idle16();
        idle32();
        test_reset();
        test_read_all_zero();
        test_bypass();
        test_collision();
        test_byte_enable();
        test_back_to_back();
        test_clear_restart();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
